// File: rtl/simt_scheduler_if.sv
// Control/status bundle between the core front-end and the SIMT scheduler.
// master = core side (drives decode/fetch/LSU status), slave = scheduler.
interface simt_scheduler_if #(
  parameter int THREADS = 4,
  parameter int PC_BITS = 8
);
  localparam int CNT_W = $clog2(THREADS) + 1;

  logic                       start;
  logic [CNT_W-1:0]           thread_count;
  logic                       decoded_mem_read_enable;
  logic                       decoded_mem_write_enable;
  logic                       decoded_ret;
  logic [2:0]                 fetcher_state;
  logic [2*THREADS-1:0]       lsu_state;
  logic [THREADS*PC_BITS-1:0] next_pc;

  logic [PC_BITS-1:0]         current_pc;
  logic [THREADS-1:0]         thread_mask;
  logic [2:0]                 core_state;
  logic                       done;
  logic                       error;

  modport master (
    output start, thread_count, decoded_mem_read_enable, decoded_mem_write_enable,
           decoded_ret, fetcher_state, lsu_state, next_pc,
    input  current_pc, thread_mask, core_state, done, error
  );

  modport slave (
    input  start, thread_count, decoded_mem_read_enable, decoded_mem_write_enable,
           decoded_ret, fetcher_state, lsu_state, next_pc,
    output current_pc, thread_mask, core_state, done, error
  );
endinterface

// File: rtl/simt_scheduler.sv
// Per-core SIMT scheduler: min-PC divergence handling, registered outputs; one pass is
// FETCH(stalls on fetcher)/DECODE/REQUEST/WAIT(stalls on masked LSUs, optional timeout)/EXECUTE/UPDATE.
module simt_scheduler #(
  parameter int THREADS      = 4,
  parameter int PC_BITS      = 8,
  parameter int WAIT_TIMEOUT = 0
) (
  input  logic             clk,
  input  logic             reset,
  simt_scheduler_if.slave  bus
);
  localparam int         CNT_W   = $clog2(THREADS) + 1;
  localparam int         WCNT_W  = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;
  localparam logic [2:0] FETCHED = 3'b010;

  typedef enum logic [2:0] {
    IDLE    = 3'b000,
    FETCH   = 3'b001,
    DECODE  = 3'b010,
    REQUEST = 3'b011,
    WAIT    = 3'b100,
    EXECUTE = 3'b101,
    UPDATE  = 3'b110,
    DONE    = 3'b111
  } state_t;

  state_t              state;
  logic [PC_BITS-1:0]  thread_pc [THREADS];
  logic [THREADS-1:0]  finished;
  logic [WCNT_W-1:0]   wait_cnt;
  logic [PC_BITS-1:0]  current_pc;
  logic [THREADS-1:0]  thread_mask;
  logic                done;
  logic                error;

  logic [CNT_W-1:0]    tc_clamped;
  logic [THREADS-1:0]  enabled;
  logic                waiting;
  logic                timeout_hit;
  logic [PC_BITS-1:0]  post_pc [THREADS];
  logic [THREADS-1:0]  post_fin;
  logic [PC_BITS-1:0]  min_pc;
  logic                any_live;
  logic [THREADS-1:0]  min_mask;

  always_comb begin
    tc_clamped = (bus.thread_count > CNT_W'(THREADS)) ? CNT_W'(THREADS) : bus.thread_count;
    enabled    = '0;
    for (int i = 0; i < THREADS; i++) begin
      enabled[i] = (CNT_W'(i) < tc_clamped);
    end
  end

  // Only LSUs of threads issuing this pass can hold the block in WAIT.
  always_comb begin
    waiting = 1'b0;
    for (int i = 0; i < THREADS; i++) begin
      if (thread_mask[i] &&
          (bus.lsu_state[2*i +: 2] == 2'b01 || bus.lsu_state[2*i +: 2] == 2'b10)) begin
        waiting = 1'b1;
      end
    end
  end

  always_comb begin
    timeout_hit = 1'b0;
    if (WAIT_TIMEOUT != 0) begin
      timeout_hit = (wait_cnt == WCNT_W'(WAIT_TIMEOUT - 1));
    end
  end

  // Post-update view of every thread, then pick the lowest live PC and its tie group.
  always_comb begin
    post_fin = finished;
    for (int i = 0; i < THREADS; i++) begin
      post_pc[i] = thread_pc[i];
      if (thread_mask[i]) begin
        if (bus.decoded_ret) begin
          post_fin[i] = 1'b1;
        end else begin
          post_pc[i] = bus.next_pc[i*PC_BITS +: PC_BITS];
        end
      end
    end

    min_pc   = '0;
    any_live = 1'b0;
    for (int i = 0; i < THREADS; i++) begin
      if (!post_fin[i] && (!any_live || post_pc[i] < min_pc)) begin
        min_pc   = post_pc[i];
        any_live = 1'b1;
      end
    end

    min_mask = '0;
    for (int i = 0; i < THREADS; i++) begin
      min_mask[i] = !post_fin[i] && (post_pc[i] == min_pc);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      current_pc  <= '0;
      thread_mask <= '0;
      done        <= 1'b0;
      error       <= 1'b0;
      finished    <= '1;
      wait_cnt    <= '0;
      for (int i = 0; i < THREADS; i++) begin
        thread_pc[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (tc_clamped == '0) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              finished    <= ~enabled;
              current_pc  <= '0;
              thread_mask <= enabled;
              for (int i = 0; i < THREADS; i++) begin
                thread_pc[i] <= '0;
              end
              state <= FETCH;
            end
          end
        end
        FETCH: begin
          if (bus.fetcher_state == FETCHED) begin
            state <= DECODE;
          end
        end
        DECODE: begin
          state <= REQUEST;
        end
        REQUEST: begin
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          if (!waiting) begin
            state <= EXECUTE;
          end else if (timeout_hit) begin
            error <= 1'b1;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            wait_cnt <= wait_cnt + WCNT_W'(1);
          end
        end
        EXECUTE: begin
          state <= UPDATE;
        end
        UPDATE: begin
          finished <= post_fin;
          for (int i = 0; i < THREADS; i++) begin
            thread_pc[i] <= post_pc[i];
          end
          if (!any_live) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            current_pc  <= min_pc;
            thread_mask <= min_mask;
            state       <= FETCH;
          end
        end
        DONE: begin
          state <= DONE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.current_pc  = current_pc;
  assign bus.thread_mask = thread_mask;
  assign bus.core_state  = state;
  assign bus.done        = done;
  assign bus.error       = error;
endmodule

// File: tb/tb_simt_scheduler.sv
// Directed bench for simt_scheduler: three parameterisations share one stimulus driver;
// a table of block launches plus hand sequences for timeout, async reset and sticky DONE.
`timescale 1ns/1ps
module tb_simt_scheduler;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd7;

  simt_scheduler_if #(.THREADS(4), .PC_BITS(8))  a_if ();
  simt_scheduler_if #(.THREADS(4), .PC_BITS(8))  b_if ();
  simt_scheduler_if #(.THREADS(8), .PC_BITS(12)) c_if ();

  simt_scheduler #(.THREADS(4), .PC_BITS(8),  .WAIT_TIMEOUT(0)) dut_a (.clk(clk), .reset(reset), .bus(a_if));
  simt_scheduler #(.THREADS(4), .PC_BITS(8),  .WAIT_TIMEOUT(8)) dut_b (.clk(clk), .reset(reset), .bus(b_if));
  simt_scheduler #(.THREADS(8), .PC_BITS(12), .WAIT_TIMEOUT(0)) dut_c (.clk(clk), .reset(reset), .bus(c_if));

  int          sel;
  logic        start;
  logic [3:0]  tc;
  logic        ret;
  logic [2:0]  fetch;
  logic [15:0] lsu;
  logic [11:0] npc [8];

  always_comb begin
    a_if.start = start && (sel == 0);
    a_if.thread_count = tc[2:0];
    a_if.decoded_mem_read_enable = 1'b0;
    a_if.decoded_mem_write_enable = 1'b0;
    a_if.decoded_ret = ret;
    a_if.fetcher_state = fetch;
    a_if.lsu_state = lsu[7:0];
    a_if.next_pc = '0;
    for (int i = 0; i < 4; i++) a_if.next_pc[i*8 +: 8] = npc[i][7:0];
  end

  always_comb begin
    b_if.start = start && (sel == 1);
    b_if.thread_count = tc[2:0];
    b_if.decoded_mem_read_enable = 1'b0;
    b_if.decoded_mem_write_enable = 1'b0;
    b_if.decoded_ret = ret;
    b_if.fetcher_state = fetch;
    b_if.lsu_state = lsu[7:0];
    b_if.next_pc = '0;
    for (int i = 0; i < 4; i++) b_if.next_pc[i*8 +: 8] = npc[i][7:0];
  end

  always_comb begin
    c_if.start = start && (sel == 2);
    c_if.thread_count = tc;
    c_if.decoded_mem_read_enable = 1'b0;
    c_if.decoded_mem_write_enable = 1'b0;
    c_if.decoded_ret = ret;
    c_if.fetcher_state = fetch;
    c_if.lsu_state = lsu;
    c_if.next_pc = '0;
    for (int i = 0; i < 8; i++) c_if.next_pc[i*12 +: 12] = npc[i];
  end

  logic [2:0]  obs_state;
  logic [11:0] obs_pc;
  logic [7:0]  obs_mask;
  logic        obs_done, obs_err;

  always_comb begin
    obs_state = a_if.core_state;
    obs_pc    = {4'h0, a_if.current_pc};
    obs_mask  = {4'h0, a_if.thread_mask};
    obs_done  = a_if.done;
    obs_err   = a_if.error;
    if (sel == 1) begin
      obs_state = b_if.core_state;
      obs_pc    = {4'h0, b_if.current_pc};
      obs_mask  = {4'h0, b_if.thread_mask};
      obs_done  = b_if.done;
      obs_err   = b_if.error;
    end else if (sel == 2) begin
      obs_state = c_if.core_state;
      obs_pc    = c_if.current_pc;
      obs_mask  = c_if.thread_mask;
      obs_done  = c_if.done;
      obs_err   = c_if.error;
    end
  end

  // Programs: 0 = linear, RET at 3; 1 = split at pc1 into {t0,t1}->2 / {t2,t3}->5, RET at 4 and 6;
  // 2 = t7 jumps to 0xFFF at pc0, others go to 1 and RET there, t7 RETs at 0xFFF.
  function automatic logic [11:0] prog_next(input int prog, input int t, input logic [11:0] pc);
    if (prog == 1 && pc == 12'd1) return (t < 2) ? 12'd2 : 12'd5;
    if (prog == 2 && pc == 12'd0) return (t == 7) ? 12'hFFF : 12'd1;
    return pc + 12'd1;
  endfunction

  function automatic logic prog_ret(input int prog, input logic [11:0] pc);
    if (prog == 1) return (pc == 12'd4) || (pc == 12'd6);
    if (prog == 2) return (pc == 12'd1) || (pc == 12'hFFF);
    return pc == 12'd3;
  endfunction

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    fetch = 3'b000;
    ret   = 1'b0;
    lsu   = 16'h0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  int          n_issue, wait_cyc, cyc_to_done;
  logic [11:0] iss_pc   [16];
  logic [7:0]  iss_mask [16];

  // Launches a block and plays fetcher/decoder/LSU until DONE or the cycle budget expires.
  // LSUs show lsu_pat for the first 'hold' WAIT cycles of each pass (0 = forever).
  task automatic run_block(input int prog, input logic [3:0] count, input logic [15:0] lsu_pat, input int hold);
    logic [2:0] prev;
    int fcyc, wpass, cyc;
    n_issue = 0; wait_cyc = 0; cyc_to_done = -1;
    fcyc = 0; wpass = 0; cyc = 0;
    @(negedge clk);
    tc = count; start = 1'b1; ret = 1'b0; fetch = 3'b000; lsu = lsu_pat;
    prev = obs_state;
    @(negedge clk);
    start = 1'b0;
    while (cyc < 2000) begin
      cyc++;
      if (obs_state == S_FETCH && prev != S_FETCH) begin
        if (n_issue < 16) begin
          iss_pc[n_issue]   = obs_pc;
          iss_mask[n_issue] = obs_mask;
        end
        n_issue++;
      end
      if (obs_state == S_WAIT) begin wait_cyc++; wpass++; end else wpass = 0;
      if (obs_state == S_FETCH) fcyc++; else fcyc = 0;
      if (obs_state == S_DONE) begin
        cyc_to_done = cyc;
        break;
      end
      fetch = (obs_state == S_FETCH && fcyc >= 2) ? 3'b010 : 3'b000;
      ret   = prog_ret(prog, obs_pc);
      for (int t = 0; t < 8; t++) npc[t] = prog_next(prog, t, obs_pc);
      lsu   = (hold == 0 || wpass <= hold) ? lsu_pat : 16'h0;
      prev  = obs_state;
      @(negedge clk);
    end
    if (cyc_to_done < 0) check("run_budget", 32'd0, 32'd1);
  endtask

  typedef struct {
    int               dut;
    int               prog;
    logic [3:0]       tc;
    logic [15:0]      lsu;
    int               hold;
    int               n_iss;
    logic [7:0][11:0] pcs;
    logic [7:0][7:0]  masks;
    int               waits;
    logic             err;
  } vec_t;

  vec_t vecs [12];

  initial begin
    reset = 1'b1; sel = 0; start = 1'b0; tc = 4'd0; ret = 1'b0; fetch = 3'b000; lsu = 16'h0;
    for (int t = 0; t < 8; t++) npc[t] = 12'h0;

    vecs[0]  = '{0, 0, 4'd4,  16'h0000, 0, 4, {48'h0, 12'd3, 12'd2, 12'd1, 12'd0},
                 {32'h0, 8'hF, 8'hF, 8'hF, 8'hF}, 4, 1'b0};
    vecs[1]  = '{0, 1, 4'd4,  16'h0000, 0, 7, {12'h0, 12'd6, 12'd5, 12'd4, 12'd3, 12'd2, 12'd1, 12'd0},
                 {8'h0, 8'hC, 8'hC, 8'h3, 8'h3, 8'h3, 8'hF, 8'hF}, 7, 1'b0};
    vecs[2]  = '{0, 0, 4'd2,  16'h0020, 0, 4, {48'h0, 12'd3, 12'd2, 12'd1, 12'd0},
                 {32'h0, 8'h3, 8'h3, 8'h3, 8'h3}, 4, 1'b0};
    vecs[3]  = '{0, 0, 4'd7,  16'h0000, 0, 4, {48'h0, 12'd3, 12'd2, 12'd1, 12'd0},
                 {32'h0, 8'hF, 8'hF, 8'hF, 8'hF}, 4, 1'b0};
    vecs[4]  = '{0, 0, 4'd0,  16'h0000, 0, 0, 96'h0, 64'h0, 0, 1'b0};
    vecs[5]  = '{2, 2, 4'd8,  16'h0000, 0, 3, {60'h0, 12'hFFF, 12'd1, 12'd0},
                 {40'h0, 8'h80, 8'h7F, 8'hFF}, 3, 1'b0};
    vecs[6]  = '{2, 2, 4'd15, 16'h0000, 0, 3, {60'h0, 12'hFFF, 12'd1, 12'd0},
                 {40'h0, 8'h80, 8'h7F, 8'hFF}, 3, 1'b0};
    vecs[7]  = '{1, 0, 4'd4,  16'h0000, 0, 4, {48'h0, 12'd3, 12'd2, 12'd1, 12'd0},
                 {32'h0, 8'hF, 8'hF, 8'hF, 8'hF}, 4, 1'b0};
    vecs[8]  = '{1, 0, 4'd4,  16'h0001, 0, 1, 96'h0, {56'h0, 8'hF}, 8, 1'b1};
    vecs[9]  = '{1, 0, 4'd4,  16'h0001, 3, 4, {48'h0, 12'd3, 12'd2, 12'd1, 12'd0},
                 {32'h0, 8'hF, 8'hF, 8'hF, 8'hF}, 16, 1'b0};
    vecs[10] = '{1, 0, 4'd4,  16'h0001, 7, 4, {48'h0, 12'd3, 12'd2, 12'd1, 12'd0},
                 {32'h0, 8'hF, 8'hF, 8'hF, 8'hF}, 32, 1'b0};
    vecs[11] = '{1, 0, 4'd3,  16'h0080, 0, 4, {48'h0, 12'd3, 12'd2, 12'd1, 12'd0},
                 {32'h0, 8'h7, 8'h7, 8'h7, 8'h7}, 4, 1'b0};

    do_reset();
    for (int d = 0; d < 3; d++) begin
      sel = d;
      #1;
      check($sformatf("rst%0d_state", d), {29'h0, obs_state}, {29'h0, S_IDLE});
      check($sformatf("rst%0d_pc", d),    {20'h0, obs_pc}, 32'h0);
      check($sformatf("rst%0d_mask", d),  {24'h0, obs_mask}, 32'h0);
      check($sformatf("rst%0d_flags", d), {30'h0, obs_done, obs_err}, 32'h0);
    end

    for (int v = 0; v < 12; v++) begin
      sel = vecs[v].dut;
      do_reset();
      run_block(vecs[v].prog, vecs[v].tc, vecs[v].lsu, vecs[v].hold);
      check($sformatf("v%0d_issues", v), n_issue, vecs[v].n_iss);
      for (int k = 0; k < vecs[v].n_iss && k < n_issue; k++) begin
        check($sformatf("v%0d_pc%0d", v, k),   {20'h0, iss_pc[k]},   {20'h0, vecs[v].pcs[k]});
        check($sformatf("v%0d_mask%0d", v, k), {24'h0, iss_mask[k]}, {24'h0, vecs[v].masks[k]});
      end
      check($sformatf("v%0d_waits", v), wait_cyc, vecs[v].waits);
      check($sformatf("v%0d_state", v), {29'h0, obs_state}, {29'h0, S_DONE});
      check($sformatf("v%0d_done", v),  {31'h0, obs_done}, 32'h1);
      check($sformatf("v%0d_error", v), {31'h0, obs_err}, {31'h0, vecs[v].err});
      if (vecs[v].n_iss == 0) check($sformatf("v%0d_latency", v), cyc_to_done, 1);
    end

    // DONE is sticky: a fresh start after a timeout changes nothing.
    sel = 1;
    do_reset();
    run_block(0, 4'd4, 16'h0001, 0);
    start = 1'b1; tc = 4'd4;
    repeat (3) @(negedge clk);
    start = 1'b0;
    check("sticky_state", {29'h0, obs_state}, {29'h0, S_DONE});
    check("sticky_flags", {30'h0, obs_done, obs_err}, 32'h3);

    // Asynchronous reset between edges while stalled in WAIT, then a clean relaunch.
    do_reset();
    @(negedge clk);
    tc = 4'd4; start = 1'b1; lsu = 16'h0001; fetch = 3'b010; ret = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 50 && obs_state != S_WAIT; k++) @(negedge clk);
    check("mw_in_wait", {29'h0, obs_state}, {29'h0, S_WAIT});
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("mw_rst_state", {29'h0, obs_state}, {29'h0, S_IDLE});
    check("mw_rst_pc",    {20'h0, obs_pc}, 32'h0);
    check("mw_rst_mask",  {24'h0, obs_mask}, 32'h0);
    check("mw_rst_flags", {30'h0, obs_done, obs_err}, 32'h0);
    #1 reset = 1'b0;
    fetch = 3'b000; lsu = 16'h0;
    run_block(0, 4'd4, 16'h0000, 0);
    check("mw_relaunch_issues", n_issue, 4);
    if (n_issue > 0) begin
      check("mw_relaunch_pc0",   {20'h0, iss_pc[0]}, 32'h0);
      check("mw_relaunch_mask0", {24'h0, iss_mask[0]}, 32'hF);
    end
    check("mw_relaunch_flags", {30'h0, obs_done, obs_err}, 32'h2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/simt_scheduler.md
Name: simt_scheduler

Overview:
- Parametrised per-core execution scheduler for the compute core.
- Sequences the FETCH/DECODE/REQUEST/WAIT/EXECUTE/UPDATE loop for one block of threads.
- Handles branch divergence with a min-PC policy: each thread keeps its own PC; each pass issues the lowest PC among live threads; an execution mask selects the threads at that PC.
- Adds a WAIT-state timeout and a per-launch active thread count.

Parameters:
THREADS, 4, threads per block (≥1)
PC_BITS, 8, program counter width
WAIT_TIMEOUT, 0, maximum cycles in WAIT before error; 0 disables the timeout

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
start  in  1  launch block (sampled in IDLE)
thread_count  in  $clog2(THREADS)+1  enabled threads; thread i is enabled iff i < thread_count; sampled in IDLE on start
decoded_mem_read_enable  in  1  decoder flag (informational, unused for sequencing)
decoded_mem_write_enable  in  1  decoder flag (informational, unused for sequencing)
decoded_ret  in  1  current instruction is RET
fetcher_state  in  3  fetcher FSM; 3'b010 = FETCHED
lsu_state  in  2*THREADS  LSU i state at [2i+1:2i]; 01 = REQUESTING, 10 = WAITING
next_pc  in  THREADS*PC_BITS  thread i next PC at [i*PC_BITS +: PC_BITS]
current_pc  out  PC_BITS  PC being issued
thread_mask  out  THREADS  threads executing current_pc
core_state  out  3  IDLE=000 FETCH=001 DECODE=010 REQUEST=011 WAIT=100 EXECUTE=101 UPDATE=110 DONE=111
done  out  1  block finished (sticky)
error  out  1  WAIT timeout occurred (sticky)

Behaviour:
- Reset (async, any state): core_state=IDLE, current_pc=0, thread_mask=0, done=0, error=0. All internal thread PCs are set to 0, the finished mask to all-ones, and the wait counter to 0.
- Internal state per thread i: thread_pc[i] (PC_BITS) and finished[i]. A thread is live iff it is not finished.
- IDLE, start=1, thread_count==0: go to DONE and set done=1. No fetch occurs.
- IDLE, start=1, thread_count>0: finished[i] = (i ≥ thread_count); thread_pc all 0; current_pc=0; thread_mask = enabled threads; go to FETCH.
- Values of thread_count above THREADS clamp to THREADS.
- FETCH: go to DECODE when fetcher_state==3'b010; otherwise hold.
- DECODE → REQUEST → EXECUTE timing: DECODE and REQUEST are one cycle each. REQUEST clears the wait counter and goes to WAIT.
- WAIT waiting condition: waiting = OR over i where thread_mask[i] of (lsu_state_i==01 or lsu_state_i==10). LSUs of unmasked threads are ignored.
- WAIT, not waiting: go to EXECUTE.
- WAIT, waiting: increment the wait counter. If WAIT_TIMEOUT≠0 and the counter reaches WAIT_TIMEOUT-1 while still waiting, set error=1, done=1 and go to DONE. This gives exactly WAIT_TIMEOUT WAIT cycles before DONE.
- EXECUTE: one cycle, then UPDATE.
- UPDATE, per-thread update: for each masked thread, if decoded_ret set finished[i]=1; else thread_pc[i] <= next_pc slice i. Unmasked threads are unchanged.
- UPDATE, reselection: computed combinationally from the post-update values. If no thread is live, set done=1 and go to DONE. Otherwise current_pc <= minimum post-update PC over live threads; thread_mask <= live threads whose post-update PC equals that minimum (ties issue together); go to FETCH.
- PC comparison is unsigned with no wrap-around handling; next_pc is taken as-is.
- DONE: hold; done and error stay set until reset; start is ignored.
- thread_mask changes only on IDLE→FETCH and UPDATE→FETCH, and is 0 in IDLE.
- Register outputs only; no combinational input-to-output paths.

Test Plan:
- THREADS=4, thread_count=4, fetcher FETCHED after 2 cycles, LSUs idle, next_pc=pc+1 for all, RET at pc=3 → current_pc 0,1,2,3; thread_mask=4'b1111 throughout; done=1, core_state=111; 4 FETCH visits.
- Divergence: at pc=1, next_pc = {t3:5, t2:5, t1:2, t0:2}; subsequent pcs +1; RET at pc 4 and 6 → issue pc2 mask 0011, pc3 mask 0011, pc4 mask 0011 (RET retires t0,t1), then pc5 mask 1100, pc6 mask 1100 → done.
- thread_count=2 → thread_mask=4'b0011 after start; LSU2 held at 10 in WAIT does not stall; thread_count=0 → DONE next cycle with no FETCH.
- WAIT_TIMEOUT=8, LSU0 stuck at 01 → exactly 8 WAIT cycles, then error=1, done=1, DONE; with the LSU released after 3 cycles → EXECUTE, error=0.
- Assert reset mid-WAIT (asynchronously, between clock edges) → outputs go to reset values immediately; a new start runs cleanly from pc=0.
- PC_BITS=12, THREADS=8, next_pc=0xFFF for t7 only, others RET → the mask converges to t7 at 0xFFF with no wrap.
